// File: rtl/escaner_teclado_pkg.sv
// escaner_teclado_pkg: shared definitions for the keypad scanner.
// Holds the scan FSM state encoding, the 4x4 keypad legend table and the code-width helper.
// Contents: estado_t + state constants, LEYENDA, leyenda(), codigo_ancho().
package escaner_teclado_pkg;

  // Scan FSM states (legacy-compatible constant encoding).
  typedef logic [1:0] estado_t;
  localparam estado_t BARRIDO       = 2'd0;
  localparam estado_t REBOTE_PULSA  = 2'd1;
  localparam estado_t ESPERA_SUELTA = 2'd2;
  localparam estado_t REBOTE_SUELTA = 2'd3;

  // Printed legend of a 4x4 keypad, indexed by {row, column}; entry 0 is the last one listed.
  // Row 0: 1 2 3 A / row 1: 4 5 6 B / row 2: 7 8 9 C / row 3: * 0 # D (* -> E, # -> F).
  localparam logic [15:0][3:0] LEYENDA = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] leyenda(input logic [1:0] fila, input logic [1:0] col);
    return LEYENDA[{fila, col}];
  endfunction

  // Code width: enough bits for every raw index, never narrower than one legend nibble.
  function automatic int codigo_ancho(input int filas, input int cols);
    int w;
    w = $clog2(filas * cols);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/escaner_teclado_mapa_tecla.sv
// mapa_tecla: combinational translation of a (row, column) key position into its output code.
// Ports: fila, col (latched key position) -> codigo (raw r*NUM_COLS+c, or the keypad legend).
// Option: ESCANER_TRADUCCION_EN selects the legend, but only for the 4x4 geometry.
module mapa_tecla
  import escaner_teclado_pkg::*;
#(
  parameter int NUM_FILAS = 4,
  parameter int NUM_COLS  = 4,
  parameter int CODIGO_W  = 4,
  parameter int FILA_W    = 2,
  parameter int COL_W     = 2
) (
  input  logic [FILA_W-1:0]   fila,
  input  logic [COL_W-1:0]    col,
  output logic [CODIGO_W-1:0] codigo
);

`ifdef ESCANER_TRADUCCION_EN
  if (NUM_FILAS == 4 && NUM_COLS == 4) begin : g_leyenda
    assign codigo = CODIGO_W'(leyenda(fila, col));
  end else begin : g_indice
    assign codigo = CODIGO_W'(int'(fila) * NUM_COLS + int'(col));
  end
`else
  assign codigo = CODIGO_W'(int'(fila) * NUM_COLS + int'(col));
`endif

endmodule

// File: rtl/escaner_teclado.sv
// escaner_teclado: scans a NUM_FILAS x NUM_COLS matrix keypad, debounces press and release, and
// holds one code per press until consumed. Ports: clk, rst (sync, active-high); filas (async,
// active-low rows); columnas (one-hot-low drive); codigo/codigo_valido/codigo_listo; desborde.
// Option: ESCANER_TRADUCCION_EN maps 4x4 keys to their printed legend instead of the raw index.
module escaner_teclado
  import escaner_teclado_pkg::*;
#(
  parameter int NUM_FILAS     = 4,
  parameter int NUM_COLS      = 4,
  parameter int SCAN_CICLOS   = 8,
  parameter int REBOTE_CICLOS = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_FILAS-1:0]                         filas,
  output logic [NUM_COLS-1:0]                          columnas,
  output logic [codigo_ancho(NUM_FILAS, NUM_COLS)-1:0] codigo,
  output logic                                         codigo_valido,
  input  logic                                         codigo_listo,
  output logic                                         desborde
);

  localparam int CODIGO_W = codigo_ancho(NUM_FILAS, NUM_COLS);
  localparam int FILA_W   = $clog2(NUM_FILAS);
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int CNT_MAX  = (SCAN_CICLOS > REBOTE_CICLOS) ? SCAN_CICLOS : REBOTE_CICLOS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  logic [NUM_FILAS-1:0] filas_meta, filas_sync;
  estado_t              estado;
  logic [COL_W-1:0]     col, col_sig;
  logic [FILA_W-1:0]    fila, fila_baja;
  logic [CNT_W-1:0]     cnt;
  logic                 activo;
  logic                 hay_baja, fila_alta, emite;
  logic [CODIGO_W-1:0]  codigo_nuevo;

  // activo is low for the reset cycle and the one after it, so the column outputs stay
  // released under reset and the first column gets its full settling time afterwards.
  assign columnas  = activo ? ~(NUM_COLS'(1) << col) : '1;
  assign col_sig   = (col == COL_W'(NUM_COLS - 1)) ? '0 : col + 1'b1;
  assign fila_alta = filas_sync[fila];

  // Lowest-index low row wins when several rows are low at the sampling point.
  always_comb begin
    fila_baja = '0;
    hay_baja  = 1'b0;
    for (int i = NUM_FILAS - 1; i >= 0; i--) begin
      if (!filas_sync[i]) begin
        fila_baja = FILA_W'(i);
        hay_baja  = 1'b1;
      end
    end
  end

  // The press is accepted on the last of REBOTE_CICLOS consecutive low samples.
  assign emite = (estado == REBOTE_PULSA) && !fila_alta && (cnt == CNT_W'(REBOTE_CICLOS - 1));

  mapa_tecla #(
    .NUM_FILAS (NUM_FILAS),
    .NUM_COLS  (NUM_COLS),
    .CODIGO_W  (CODIGO_W),
    .FILA_W    (FILA_W),
    .COL_W     (COL_W)
  ) u_mapa (
    .fila   (fila),
    .col    (col),
    .codigo (codigo_nuevo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      filas_meta <= '1;
      filas_sync <= '1;
      estado     <= BARRIDO;
      col        <= '0;
      fila       <= '0;
      cnt        <= '0;
      activo     <= 1'b0;
    end else begin
      filas_meta <= filas;
      filas_sync <= filas_meta;
      activo     <= 1'b1;
      case (estado)
        BARRIDO: begin
          if (activo) begin
            // Sampling after SCAN_CICLOS driven clocks covers the 2-flop synchroniser delay.
            if (cnt == CNT_W'(SCAN_CICLOS - 1)) begin
              cnt <= '0;
              if (hay_baja) begin
                fila   <= fila_baja;
                estado <= REBOTE_PULSA;
              end else begin
                col <= col_sig;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        REBOTE_PULSA: begin
          if (fila_alta) begin
            estado <= BARRIDO;
            col    <= col_sig;
            cnt    <= '0;
          end else if (cnt == CNT_W'(REBOTE_CICLOS - 1)) begin
            estado <= ESPERA_SUELTA;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ESPERA_SUELTA: begin
          if (fila_alta) begin
            estado <= REBOTE_SUELTA;
            cnt    <= '0;
          end
        end
        REBOTE_SUELTA: begin
          if (!fila_alta) begin
            estado <= ESPERA_SUELTA;
            cnt    <= '0;
          end else if (cnt == CNT_W'(REBOTE_CICLOS - 1)) begin
            estado <= BARRIDO;
            col    <= col_sig;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          estado <= BARRIDO;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Output register: a new key is taken only into an empty or just-consumed slot;
  // otherwise it is dropped and the sticky overflow flag records the loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      codigo        <= '0;
      codigo_valido <= 1'b0;
      desborde      <= 1'b0;
    end else if (emite) begin
      if (!codigo_valido || codigo_listo) begin
        codigo        <= codigo_nuevo;
        codigo_valido <= 1'b1;
      end else begin
        desborde <= 1'b1;
      end
    end else if (codigo_listo) begin
      codigo_valido <= 1'b0;
    end
  end

endmodule

// File: doc/escaner_teclado.md
ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 SHALL have parameter NUM_FILAS, default 4, number of keypad rows (2..8).
REQ-002 SHALL have parameter NUM_COLS, default 4, number of keypad columns (2..8).
REQ-003 SHALL have parameter SCAN_CICLOS, default 8, clocks each column is driven before its rows are sampled (>=3).
REQ-004 SHALL have parameter REBOTE_CICLOS, default 16, consecutive stable clocks needed for press or release (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port filas  input  NUM_FILAS  keypad rows, asynchronous, active-low, externally pulled up.
REQ-008 SHALL have port columnas  output  NUM_COLS  column drive, one-hot active-low; all high when not scanning.
REQ-009 SHALL have port codigo  output  CODIGO_W  key code; CODIGO_W = max(4, clog2(NUM_FILAS*NUM_COLS)).
REQ-010 SHALL have port codigo_valido  output  1  codigo holds an unconsumed key.
REQ-011 SHALL have port codigo_listo  input  1  consumer accepts codigo this cycle.
REQ-012 SHALL have port desborde  output  1  sticky flag: a debounced key was dropped.

Function
REQ-013 SHALL pass filas through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-014 SHALL implement FSM states BARRIDO, REBOTE_PULSA, ESPERA_SUELTA, REBOTE_SUELTA.
REQ-015 BARRIDO SHALL drive column c low for SCAN_CICLOS clocks, then sample rows; no row low -> c advances, NUM_COLS-1 wraps to 0.
REQ-016 BARRIDO with any row low SHALL latch c and the lowest-index low row r, keep column c driven, enter REBOTE_PULSA.
REQ-017 REBOTE_PULSA SHALL count while row r stays low; REBOTE_CICLOS consecutive low samples -> emit key, enter ESPERA_SUELTA.
REQ-018 REBOTE_PULSA with row r high on any sample SHALL emit nothing and return to BARRIDO at column c+1 (with wrap).
REQ-019 ESPERA_SUELTA SHALL keep column c driven until row r is high, then enter REBOTE_SUELTA.
REQ-020 REBOTE_SUELTA SHALL require REBOTE_CICLOS consecutive high samples of row r before BARRIDO at column c+1; a low sample returns to ESPERA_SUELTA with no new key.
REQ-021 Other keys pressed while a key is held SHALL be ignored until the held key's release completes; one press yields exactly one key.
REQ-022 Emission SHALL load codigo and set codigo_valido on the next clock; emission-to-valid latency is 1 clock.
REQ-023 codigo_valido SHALL stay high and codigo stable until a cycle with codigo_valido and codigo_listo both high; it clears on the following clock.
REQ-024 Emission while codigo_valido is high and codigo_listo is low SHALL drop the new key and set desborde; held codigo is unchanged.
REQ-025 Emission in the same cycle as a consumption SHALL load the new key, keep codigo_valido high, and leave desborde unchanged.
REQ-026 Untranslated key code SHALL be r*NUM_COLS + c, zero-extended to CODIGO_W.
REQ-027 desborde SHALL clear only on reset.

Reset
REQ-028 rst SHALL put the FSM in BARRIDO at column 0 and clear counters and synchroniser to all-ones rows.
REQ-029 Under rst, columnas SHALL be all ones, codigo 0, codigo_valido 0, desborde 0.
REQ-030 rst mid-debounce or mid-hold SHALL discard the key in progress; no key is emitted for it.

Configuration
REQ-031 With ESCANER_TRADUCCION_EN defined and NUM_FILAS=NUM_COLS=4, codigo SHALL be the keypad legend.
REQ-032 The legend is row 0: 1,2,3,A (0x1,0x2,0x3,0xA); row 1: 4,5,6,B (0x4,0x5,0x6,0xB); row 2: 7,8,9,C (0x7,0x8,0x9,0xC); row 3: *,0,#,D (0xE,0x0,0xF,0xD).
REQ-033 Without ESCANER_TRADUCCION_EN, or with it defined at any other geometry, codigo SHALL be the raw index of REQ-026.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the legend table and the CODIGO_W function.
REQ-035 Translation SHALL be a sub-module mapa_tecla: combinational (row, column) -> code.
REQ-036 Scan FSM, debounce counters and output register SHALL be in escaner_teclado; total RTL 120-400 lines.

Verification
REQ-037 Defaults, ESCANER_TRADUCCION_EN on: press row 1/col 2 for 40 clocks, codigo_listo=1 -> one pulse, codigo=0x6, then release.
REQ-038 Defaults, macro off: press row 3/col 3 -> codigo=0xF; press row 3/col 1 -> codigo=0xD.
REQ-039 REBOTE_CICLOS=16: glitch row 0/col 0 low for 10 clocks -> no codigo_valido; scan resumes at column 1.
REQ-040 codigo_listo=0: press key 5 then key 9 -> codigo stays 0x5, desborde=1; raising codigo_listo clears codigo_valido next clock.
REQ-041 Hold key 2 and press key 8 during hold -> only 0x2 emitted; release both -> scan resumes, no extra key.
REQ-042 Assert rst during REBOTE_PULSA -> next clock columnas=all ones, codigo_valido=0, FSM in BARRIDO at column 0.
